// File: rtl/sccb_master.sv
// ============================================================================
// Module   : sccb_master
// Function : write-only SCCB byte master framing strobed bytes into one
//            start..stop phase on SIOC/SIOD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_master #(
  parameter int unsigned QTR_TICKS = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2cStrobe,
  input  logic [7:0] dataToSend,
  input  logic       lastTransfer,
  output logic       sda,
  output logic       scl,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  localparam logic [15:0] C_TICK_MAX = 16'(QTR_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [1:0]  qcnt_q, qcnt_d;
  logic [15:0] tick_q, tick_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        busy_q, busy_d;
  logic        w_wrap;

  assign w_wrap = (tick_q == C_TICK_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'd0;
      last_q   <= 1'b0;
      bitcnt_q <= 3'd0;
      qcnt_q   <= 2'd0;
      tick_q   <= 16'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      bitcnt_q <= bitcnt_d;
      qcnt_q   <= qcnt_d;
      tick_q   <= tick_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    qcnt_d   = qcnt_q;
    tick_d   = tick_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        tick_d = 16'd0;
        if (i2cStrobe) begin
          shift_d  = dataToSend;
          last_d   = lastTransfer;
          qcnt_d   = 2'd0;
          bitcnt_d = 3'd7;
          // A strobe in HOLD continues the open phase without a repeated start.
          state_d  = (state_q == S_IDLE) ? S_START : S_BIT;
        end
      end
      default: begin
        if (!w_wrap) begin
          tick_d = tick_q + 16'd1;
        end else begin
          tick_d = 16'd0;
          qcnt_d = qcnt_q + 2'd1;
          case (state_q)
            S_START: begin
              if (qcnt_q == 2'd1) begin
                state_d  = S_BIT;
                qcnt_d   = 2'd0;
                bitcnt_d = 3'd7;
              end
            end
            S_BIT: begin
              if (qcnt_q == 2'd3) begin
                shift_d = {shift_q[6:0], 1'b0};
                if (bitcnt_q == 3'd0) begin
                  state_d = S_ACK;
                end else begin
                  bitcnt_d = bitcnt_q - 3'd1;
                end
              end
            end
            S_ACK: begin
              if (qcnt_q == 2'd3) begin
                state_d = last_q ? S_STOP : S_HOLD;
                qcnt_d  = 2'd0;
              end
            end
            S_STOP: begin
              if (qcnt_q == 2'd2) begin
                state_d = S_IDLE;
                qcnt_d  = 2'd0;
              end
            end
            default: begin
              state_d = S_IDLE;
              qcnt_d  = 2'd0;
            end
          endcase
        end
      end
    endcase
  end

  // Pin levels are decoded from the next state so they register on the quarter edge.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE:  busy_d = 1'b0;
      S_START: begin
        sda_d = 1'b0;
        scl_d = (qcnt_d == 2'd0);
      end
      S_BIT: begin
        sda_d = shift_d[7];
        scl_d = (qcnt_d == 2'd1) || (qcnt_d == 2'd2);
      end
      S_ACK:   scl_d = (qcnt_d == 2'd1) || (qcnt_d == 2'd2);
      S_STOP: begin
        scl_d = (qcnt_d != 2'd0);
        sda_d = (qcnt_d == 2'd2);
      end
      S_HOLD: begin
        scl_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign scl  = scl_q;
  assign sda  = sda_q;
  assign busy = busy_q;

endmodule

`default_nettype wire
